// File: rtl/fetch_unit.sv
// Instruction fetch and next-PC logic: owns PC, IR and a return-address stack,
// and applies IF/ID/EX strobes from the stage controller with IF > ID > EX priority.
module fetch_unit #(
    parameter int              PC_W      = 16,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter int              RAS_DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable_IF,
    input  logic            enable_ID,
    input  logic            enable_EX,
    input  logic            branch_taken,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_rdata,
    output logic [15:0]     ir,
    output logic [3:0]      opcode,
    output logic [PC_W-1:0] pc,
    output logic            ras_overflow,
    output logic            ras_underflow,
    output logic [15:0]     instr_count
);

    localparam int IDX_W = $clog2(RAS_DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam logic [PTR_W-1:0] RAS_FULL = PTR_W'(RAS_DEPTH);

    logic [PC_W-1:0]  pc_reg;
    logic [15:0]      ir_reg;
    logic [15:0]      instr_count_reg;
    logic [PTR_W-1:0] ras_ptr_reg;
    logic             ras_overflow_reg;
    logic             ras_underflow_reg;
    logic [PC_W-1:0]  ras_mem [RAS_DEPTH];

    logic [PC_W-1:0]  jump_target;
    logic [PC_W-1:0]  branch_target;
    logic [PC_W-1:0]  ret_addr;
    logic [IDX_W-1:0] push_idx;
    logic [IDX_W-1:0] pop_idx;
    logic             is_jmp;
    logic             is_call;
    logic             is_ret;
    logic             is_branch;
    logic             ras_full;
    logic             ras_empty;
    logic             push_en;

    // JMP/CALL keep the upper PC bits (post-increment) and replace the low 12.
    generate
        if (PC_W > 12) begin : g_jump_page
            assign jump_target = {pc_reg[PC_W-1:12], ir_reg[11:0]};
        end else begin : g_jump_full
            assign jump_target = ir_reg[PC_W-1:0];
        end
    endgenerate

    always_comb begin
        is_jmp        = (ir_reg[15:12] == 4'hC);
        is_call       = (ir_reg[15:12] == 4'hD);
        is_ret        = (ir_reg[15:12] == 4'hE);
        is_branch     = (ir_reg[15:14] == 2'b10);
        ras_full      = (ras_ptr_reg == RAS_FULL);
        ras_empty     = (ras_ptr_reg == '0);
        push_idx      = ras_ptr_reg[IDX_W-1:0];
        pop_idx       = push_idx - 1'b1;
        ret_addr      = ras_mem[pop_idx];
        branch_target = pc_reg + {{(PC_W-8){ir_reg[7]}}, ir_reg[7:0]};
        push_en       = enable_ID && !enable_IF && is_call && !ras_full && !rst;
    end

    // Stack storage carries no reset; only the pointer defines validity.
    always_ff @(posedge clk) begin
        if (push_en) begin
            ras_mem[push_idx] <= pc_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg            <= RESET_PC;
            ir_reg            <= '0;
            instr_count_reg   <= '0;
            ras_ptr_reg       <= '0;
            ras_overflow_reg  <= 1'b0;
            ras_underflow_reg <= 1'b0;
        end else if (enable_IF) begin
            ir_reg          <= imem_rdata;
            pc_reg          <= pc_reg + 1'b1;
            instr_count_reg <= instr_count_reg + 16'd1;
        end else if (enable_ID) begin
            if (is_jmp) begin
                pc_reg <= jump_target;
            end else if (is_call) begin
                pc_reg <= jump_target;
                if (ras_full) begin
                    ras_overflow_reg <= 1'b1;
                end else begin
                    ras_ptr_reg <= ras_ptr_reg + 1'b1;
                end
            end else if (is_ret) begin
                if (ras_empty) begin
                    ras_underflow_reg <= 1'b1;
                end else begin
                    pc_reg      <= ret_addr;
                    ras_ptr_reg <= ras_ptr_reg - 1'b1;
                end
            end
        end else if (enable_EX && is_branch && branch_taken) begin
            pc_reg <= branch_target;
        end
    end

    assign imem_addr     = pc_reg;
    assign pc            = pc_reg;
    assign ir            = ir_reg;
    assign opcode        = ir_reg[15:12];
    assign ras_overflow  = ras_overflow_reg;
    assign ras_underflow = ras_underflow_reg;
    assign instr_count   = instr_count_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized and directed stimulus for fetch_unit; a queue-based reference model
// predicts state after every clock and a negedge monitor compares it.
module tb_fetch_unit;

    localparam logic [15:0] RST_PC = 16'h0010;
    localparam int          DEPTH  = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable_IF = 1'b0;
    logic        enable_ID = 1'b0;
    logic        enable_EX = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata = 16'h0000;
    logic [15:0] ir;
    logic [3:0]  opcode;
    logic [15:0] pc;
    logic        ras_overflow;
    logic        ras_underflow;
    logic [15:0] instr_count;

    fetch_unit #(.PC_W(16), .RESET_PC(RST_PC), .RAS_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .enable_IF(enable_IF), .enable_ID(enable_ID), .enable_EX(enable_EX),
        .branch_taken(branch_taken),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .ir(ir), .opcode(opcode), .pc(pc),
        .ras_overflow(ras_overflow), .ras_underflow(ras_underflow),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] ir;
        logic        ovf;
        logic        unf;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state
    logic [15:0] m_pc = 16'h0;
    logic [15:0] m_ir = 16'h0;
    logic [15:0] m_stack[$];
    logic        m_ovf = 1'b0;
    logic        m_unf = 1'b0;
    logic [15:0] m_cnt = 16'h0;

    task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic model_update(input bit r, input bit i_f, input bit i_d, input bit i_e,
                                input bit bt, input logic [15:0] rd);
        int op;
        int off;
        op = int'(m_ir[15:12]);
        if (r) begin
            m_pc = RST_PC; m_ir = 16'h0; m_stack.delete();
            m_ovf = 1'b0; m_unf = 1'b0; m_cnt = 16'h0;
        end else if (i_f) begin
            m_ir  = rd;
            m_pc  = m_pc + 16'd1;
            m_cnt = m_cnt + 16'd1;
        end else if (i_d) begin
            if (op == 12) begin
                m_pc = (m_pc & 16'hF000) | (m_ir & 16'h0FFF);
            end else if (op == 13) begin
                if (m_stack.size() == DEPTH) m_ovf = 1'b1;
                else m_stack.push_back(m_pc);
                m_pc = (m_pc & 16'hF000) | (m_ir & 16'h0FFF);
            end else if (op == 14) begin
                if (m_stack.size() == 0) m_unf = 1'b1;
                else m_pc = m_stack.pop_back();
            end
        end else if (i_e && op >= 8 && op <= 11 && bt) begin
            off = int'(m_ir[7:0]);
            if (off > 127) off -= 256;
            m_pc = 16'(int'(m_pc) + off);
        end
    endtask

    // One clock of stimulus; expectation is queued for the monitor.
    task automatic step(input bit r, input bit i_f, input bit i_d, input bit i_e,
                        input bit bt, input logic [15:0] rd);
        exp_t e;
        @(negedge clk);
        #2;
        rst = r; enable_IF = i_f; enable_ID = i_d; enable_EX = i_e;
        branch_taken = bt; imem_rdata = rd;
        model_update(r, i_f, i_d, i_e, bt, rd);
        e.pc = m_pc; e.ir = m_ir; e.ovf = m_ovf; e.unf = m_unf; e.cnt = m_cnt;
        sb.push_back(e);
    endtask

    task automatic fetch(input logic [15:0] instr);
        step(0, 1, 0, 0, 0, instr);
    endtask

    task automatic decode();
        step(0, 0, 1, 0, 0, 16'h0);
    endtask

    // Direct spec-value checks just after the edge of the most recent step.
    task automatic expect_pc_flags(input string nm, input logic [15:0] epc,
                                   input logic eovf, input logic eunf);
        @(posedge clk);
        #1;
        cmp({nm, "_pc"}, pc, epc);
        cmp({nm, "_ovf"}, 16'(ras_overflow), 16'(eovf));
        cmp({nm, "_unf"}, 16'(ras_underflow), 16'(eunf));
    endtask

    task automatic expect_ir_cnt(input string nm, input logic [15:0] eir, input logic [15:0] ecnt);
        cmp({nm, "_ir"}, ir, eir);
        cmp({nm, "_cnt"}, instr_count, ecnt);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            cmp("sb_pc", pc, mon_e.pc);
            cmp("sb_imem_addr", imem_addr, mon_e.pc);
            cmp("sb_ir", ir, mon_e.ir);
            cmp("sb_opcode", 16'(opcode), 16'(mon_e.ir[15:12]));
            cmp("sb_ovf", 16'(ras_overflow), 16'(mon_e.ovf));
            cmp("sb_unf", 16'(ras_underflow), 16'(mon_e.unf));
            cmp("sb_cnt", instr_count, mon_e.cnt);
        end
    end

    initial begin
        int sel;
        logic [15:0] instr;

        // Reset, then a plain fetch
        step(1, 0, 0, 0, 0, 16'h0);
        expect_pc_flags("reset", RST_PC, 0, 0);
        expect_ir_cnt("reset", 16'h0000, 16'h0000);
        fetch(16'h0123);
        expect_pc_flags("if1", 16'h0011, 0, 0);
        expect_ir_cnt("if1", 16'h0123, 16'h0001);
        cmp("if1_opcode", 16'(opcode), 16'h0000);

        // Walk into page 0x2000 with page-local jumps, then JMP there
        fetch(16'hCFFF); decode();
        fetch(16'h0000);
        fetch(16'hCFFF); decode();
        fetch(16'h0000);
        fetch(16'hC005); decode();
        expect_pc_flags("reach2005", 16'h2005, 0, 0);
        fetch(16'hC0A0); decode();
        expect_pc_flags("jmp", 16'h20A0, 0, 0);

        // CALL / RET pair, then RET on the emptied stack
        step(1, 0, 0, 0, 0, 16'h0);
        fetch(16'hC040); decode();
        fetch(16'hD100); decode();
        expect_pc_flags("call", 16'h0100, 0, 0);
        fetch(16'hE000); decode();
        expect_pc_flags("ret", 16'h0041, 0, 0);
        fetch(16'hE000); decode();
        expect_pc_flags("ret_empty", 16'h0042, 0, 1);

        // Backward branch, taken and not taken
        step(1, 0, 0, 0, 0, 16'h0);
        fetch(16'hC050); decode();
        fetch(16'h80FC); decode();
        step(0, 0, 0, 1, 1, 16'h0);
        expect_pc_flags("br_taken", 16'h004D, 0, 0);
        fetch(16'hC050); decode();
        fetch(16'h80FC); decode();
        step(0, 0, 0, 1, 0, 16'h0);
        expect_pc_flags("br_not_taken", 16'h0051, 0, 0);

        // Nine CALLs overflow an 8-deep stack; nine RETs then underflow
        step(1, 0, 0, 0, 0, 16'h0);
        for (int i = 0; i < 9; i++) begin
            fetch(16'hD100 + 16'(i)); decode();
        end
        expect_pc_flags("call9", 16'h0108, 1, 0);
        for (int i = 0; i < 8; i++) begin
            fetch(16'hE000); decode();
        end
        expect_pc_flags("ret8", 16'h0011, 1, 0);
        fetch(16'hE000); decode();
        expect_pc_flags("ret9", 16'h0012, 1, 1);

        // Reset during a CALL's ID cycle, then IF+ID together
        fetch(16'hD300);
        step(1, 0, 1, 0, 0, 16'h0);
        expect_pc_flags("rst_mid", RST_PC, 0, 0);
        expect_ir_cnt("rst_mid", 16'h0000, 16'h0000);
        fetch(16'hC0A0);
        step(0, 1, 1, 0, 0, 16'h0000);
        expect_pc_flags("if_id_prio", 16'h0012, 0, 0);
        expect_ir_cnt("if_id_prio", 16'h0000, 16'h0002);
        fetch(16'hE000); decode();
        expect_pc_flags("ras_empty_after_rst", 16'h0013, 0, 1);

        // Randomized instruction stream with occasional resets and odd strobes
        for (int n = 0; n < 400; n++) begin
            sel = int'($urandom_range(0, 19));
            if (sel == 0) begin
                step(1, $urandom_range(0, 1), $urandom_range(0, 1), 0, 0, 16'(($urandom)));
            end else if (sel == 1) begin
                step(0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                     $urandom_range(0, 1), 16'($urandom));
            end else if (sel == 2) begin
                step(0, 0, 0, 0, $urandom_range(0, 1), 16'($urandom));
            end else begin
                sel = int'($urandom_range(0, 9));
                instr = 16'($urandom);
                case (sel)
                    0, 1:    instr[15:12] = 4'hD;
                    2, 3:    instr[15:12] = 4'hE;
                    4:       instr[15:12] = 4'hC;
                    5, 6, 7: instr[15:14] = 2'b10;
                    default: instr[15:12] = 4'(($urandom_range(0, 8) == 8) ? 15 : $urandom_range(0, 7));
                endcase
                fetch(instr);
                decode();
                step(0, 0, 0, 1, $urandom_range(0, 1), 16'($urandom));
            end
        end
        step(0, 0, 0, 0, 0, 16'h0);

        // Bounded drain of the scoreboard
        for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL sb_drain actual=%0d required=0 entries left", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch and next-PC block feeding the multi-cycle stage controller. It owns the PC, the instruction register (IR) and an internal return-address stack (RAS). It drives the 4-bit opcode consumed by the stage controller and updates the PC from the controller's enable_IF, enable_ID and enable_EX strobes.

Parameters:
PC_W, 16, PC and instruction-address width (word addressed)
RESET_PC, 16'h0000, PC value loaded on reset
RAS_DEPTH, 8, return-address stack entries (power of two, 2..16)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
enable_IF  in  1  stage-controller IF strobe
enable_ID  in  1  stage-controller ID strobe
enable_EX  in  1  stage-controller EX strobe
branch_taken  in  1  ALU branch condition, sampled only on branch EX cycles
imem_addr  out  PC_W  instruction memory address, = pc (combinational)
imem_rdata  in  16  instruction word at imem_addr, combinational read
ir  out  16  instruction register
opcode  out  4  = ir[15:12]
pc  out  PC_W  current PC
ras_overflow  out  1  sticky: CALL issued with RAS full
ras_underflow  out  1  sticky: RET issued with RAS empty
instr_count  out  16  number of IF cycles since reset

Behaviour:
- Reset (rst=1 at edge, regardless of enables): pc<=RESET_PC, ir<=0 (opcode 0), RAS pointer<=0, ras_overflow/ras_underflow<=0, instr_count<=0. RAS entry contents are don't-care. Reset mid-instruction discards all in-flight state.
- Instruction format: [15:12] opcode, [11:0] imm12 for JMP/CALL, [7:0] signed branch offset for branches.
- Opcode classes: 1100 JMP, 1101 CALL, 1110 RET (resolved in ID); 1000-1011 conditional branches (resolved in EX); all others sequential.
- IF cycle (enable_IF=1): ir<=imem_rdata; pc<=pc+1 (wraps at 2^PC_W); instr_count<=instr_count+1 (wraps at 16'hFFFF->0). One-cycle latency: the new opcode is valid the cycle after IF, i.e. during ID.
- ID cycle (enable_ID=1), based on ir[15:12]:
  - JMP: pc<={pc[PC_W-1:12], imm12}, with pc already incremented.
  - CALL: push pc (the return address) then jump as JMP. If RAS is full: no push, ras_overflow<=1, jump still taken.
  - RET: pop; pc<=top entry. If RAS is empty: pc unchanged (falls through), ras_underflow<=1, pointer stays 0.
  - Other opcodes: no change.
- EX cycle (enable_EX=1) with opcode 1000-1011: if branch_taken, pc<=pc+sign_extend(ir[7:0]) modulo 2^PC_W; otherwise pc unchanged. branch_taken is ignored for all other opcodes and cycles.
- RAS: pointer counts 0..RAS_DEPTH. A push writes entry[ptr] and increments ptr. A pop reads entry[ptr-1] and decrements ptr. Full when ptr==RAS_DEPTH.
- Flags are sticky until reset.
- Enables are one-hot by contract. If more than one is high, priority is IF > ID > EX and the lower ones are ignored that cycle. With no enable high, all state holds.
- Outputs are registered except imem_addr and opcode, which are direct decodes of registers.

Test Plan:
1. Reset with RESET_PC=16'h0010, then IF with imem_rdata=16'h0123 -> ir=16'h0123, opcode=0, pc=16'h0011, instr_count=1.
2. At pc=16'h2005, fetch JMP 16'hC0A0, then ID -> pc=16'h20A0; ras_overflow and ras_underflow stay 0.
3. CALL 16'hD100 fetched at pc=16'h0040, then ID -> pc=16'h0100 and RAS holds 16'h0041. Fetch RET 16'hE000 at 16'h0100, then ID -> pc=16'h0041 and RAS is empty.
4. Branch 16'h80FC fetched at pc=16'h0050 (pc becomes 16'h0051):
   - EX with branch_taken=1 -> pc=16'h004D.
   - Same sequence with branch_taken=0 -> pc=16'h0051.
5. Nine CALLs with RAS_DEPTH=8 -> 9th CALL still jumps and ras_overflow=1. Nine RETs return through the 8 stacked addresses; the 9th sets ras_underflow=1 and leaves pc unchanged.
6. Assert rst during an ID cycle of a CALL -> next cycle pc=RESET_PC, ir=0, RAS empty, both flags 0, instr_count=0. Also assert enable_IF and enable_ID together -> only the IF update occurs.
